// File: rtl/mem_access_stage_if.sv
// Data-memory port of the MEM stage: request/acknowledge bus between the
// pipeline (master) and the data memory (slave).
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: ALU pass-through, load/store bus transaction with timeout,
// byte-lane generation and load sign/zero extension. Stalls upstream while busy.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [31:0]                alu_result_in,
    input  logic [31:0]                store_data_in,
    input  logic                       mem_read_in,
    input  logic                       mem_write_in,
    input  logic [1:0]                 mem_size_in,
    input  logic                       mem_unsigned_in,
    input  logic                       reg_write_en_in,
    input  logic [4:0]                 reg_addr_in,
    mem_access_stage_if.master         dmem,
    output logic                       stall,
    output logic [31:0]                data_out,
    output logic                       reg_write_en_out,
    output logic [4:0]                 reg_addr_out,
    output logic                       misalign_out,
    output logic                       bus_err_out
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;

    logic [1:0]  byte_off;
    logic        is_word, is_half;
    logic        mem_op, misaligned;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    assign byte_off   = alu_result_in[1:0];
    assign is_word    = mem_size_in[1];
    assign is_half    = (mem_size_in == 2'b01);
    assign mem_op     = valid_in & (mem_read_in | mem_write_in);
    assign misaligned = mem_op & ((is_half & byte_off[0]) | (is_word & (byte_off != 2'b00)));

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;
    assign reg_addr_out    = reg_addr_in;

    // Little-endian lane placement; sub-word store data is replicated on every lane.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = store_data_in;
        if (is_half) begin
            lane_be    = byte_off[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{store_data_in[15:0]}};
        end else if (!is_word) begin
            lane_be    = 4'b0001 << byte_off;
            lane_wdata = {4{store_data_in[7:0]}};
        end
    end

    assign ld_byte = dmem.dmem_rdata[{byte_off, 3'b000} +: 8];
    assign ld_half = dmem.dmem_rdata[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = dmem.dmem_rdata;
        if (is_half) begin
            load_ext = {{16{~mem_unsigned_in & ld_half[15]}}, ld_half};
        end else if (!is_word) begin
            load_ext = {{24{~mem_unsigned_in & ld_byte[7]}}, ld_byte};
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        result_d         = result_q;
        req_d            = req_q;
        we_d             = we_q;
        addr_d           = addr_q;
        be_d             = be_q;
        wdata_d          = wdata_q;
        stall            = 1'b0;
        data_out         = alu_result_in;
        reg_write_en_out = reg_write_en_in & valid_in;
        misalign_out     = 1'b0;
        bus_err_out      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (misaligned) begin
                    misalign_out     = 1'b1;
                    reg_write_en_out = 1'b0;
                    data_out         = 32'h0;
                end else if (mem_op) begin
                    stall            = 1'b1;
                    reg_write_en_out = 1'b0;
                    state_d          = ST_BUSY;
                    req_d            = 1'b1;
                    we_d             = mem_write_in;
                    addr_d           = {alu_result_in[31:2], 2'b00};
                    be_d             = lane_be;
                    wdata_d          = lane_wdata;
                    cnt_d            = 8'd0;
                end
            end
            ST_BUSY: begin
                stall            = 1'b1;
                reg_write_en_out = 1'b0;
                // An ack arriving on the timeout cycle still completes normally.
                if (dmem.dmem_ack) begin
                    result_d = mem_write_in ? 32'h0 : load_ext;
                    req_d    = 1'b0;
                    state_d  = ST_DONE;
                end else if (cnt_q == TMO_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                data_out         = result_q;
                reg_write_en_out = reg_write_en_in & mem_read_in & ~mem_write_in & ~err_q;
                bus_err_out      = err_q;
                state_d          = ST_IDLE;
                err_d            = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase

        if (!rst) begin
            stall            = 1'b0;
            misalign_out     = 1'b0;
            bus_err_out      = 1'b0;
            reg_write_en_out = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            result_q <= 32'h0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 32'h0;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            result_q <= result_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
        end
    end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the five-stage pipeline, between the EX/MEM register and the MEM/WB register. ALU results pass straight through to MEM/WB. Loads and stores run a request/acknowledge transaction on the data-memory port, with a timeout. While a transaction is in flight, the block stalls the upstream pipeline. It generates byte lanes and performs load extraction with sign or zero extension.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: number of BUSY cycles without dmem_ack before a bus error is declared (1..255; counter is 8 bits).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-low reset.
- valid_in  in  1  EX/MEM holds a live instruction.
- alu_result_in  in  32  memory byte address, or the result of an ALU instruction.
- store_data_in  in  32  store source (rt) value.
- mem_read_in, mem_write_in  in  1 each  load / store.
- mem_size_in  in  2  access size: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- mem_unsigned_in  in  1  zero-extend a load (otherwise sign-extend).
- reg_write_en_in  in  1  instruction writes a register.
- reg_addr_in  in  5  destination register.
- dmem_req  out  1  request to data memory, registered.
- dmem_we  out  1  write strobe, registered.
- dmem_addr  out  32  word address, {addr[31:2], 2'b00}, registered.
- dmem_be  out  4  byte enables, registered.
- dmem_wdata  out  32  lane-replicated write data, registered.
- dmem_rdata  in  32  read data; valid in the cycle dmem_ack is high.
- dmem_ack  in  1  transaction complete.
- stall  out  1  hold all upstream stages.
- data_out  out  32  to MEM/WB data_in.
- reg_write_en_out  out  1  to MEM/WB reg_write_en_in.
- reg_addr_out  out  5  to MEM/WB reg_addr_in; always equals reg_addr_in.
- misalign_out  out  1  misaligned access, single-cycle flag.
- bus_err_out  out  1  memory timeout, asserted in DONE.

## Operation
- Decode:
  - A memory op is valid_in & (mem_read_in | mem_write_in).
  - If both read and write are set, the instruction is a store.
  - A store never writes a register: reg_write_en_out = 0.
- Non-memory op, or valid_in = 0:
  - Combinational pass-through: data_out = alu_result_in.
  - reg_write_en_out = reg_write_en_in & valid_in.
  - stall = 0.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] != 0.
  - No request is issued and stall = 0.
  - misalign_out = 1, reg_write_en_out = 0, data_out = 0, all for that cycle only.
- Byte lanes (little-endian, a = addr[1:0]):
  - Byte: be = 4'b0001 << a, wdata = {4{sd[7:0]}}.
  - Half: be = a[1] ? 4'b1100 : 4'b0011, wdata = {2{sd[15:0]}}.
  - Word: be = 4'b1111, wdata = sd.
- Load extraction:
  - Byte: rdata[8a+7 : 8a].
  - Half: rdata[16·a[1]+15 : 16·a[1]].
  - Extend to 32 bits with sign or zero per mem_unsigned_in.
- State machine, with states IDLE, BUSY and DONE:
  - IDLE:
    - An aligned memory op drives stall = 1 and the next state is BUSY.
    - At that edge, the dmem_* registers are loaded and dmem_req <= 1.
    - Counter <= 0.
  - BUSY:
    - stall = 1 and dmem_req is held high.
    - On dmem_ack: load the result register with the extended rdata (stores load 0), set dmem_req <= 0, go to DONE.
    - Otherwise the counter increments. At counter == TIMEOUT_CYCLES-1 without ack: dmem_req <= 0, the error flag <= 1, go to DONE.
  - DONE:
    - stall = 0 and data_out = the result register.
    - reg_write_en_out = reg_write_en_in & mem_read_in & ~mem_write_in & ~err.
    - bus_err_out = err.
    - Next state is IDLE and err is cleared.
- dmem_ack is ignored in IDLE and DONE.
- EX/MEM is held by stall, so the inputs stay stable from IDLE through DONE.

## Timing
- Reset (rst = 0 at an edge):
  - State = IDLE, dmem_req = 0, dmem_we = 0, dmem_be = 0, dmem_addr = 0, dmem_wdata = 0.
  - Counter = 0, result register = 0, err = 0.
  - While rst = 0: stall = 0, misalign_out = 0, bus_err_out = 0, reg_write_en_out = 0.
- Reset mid-transaction: the request is dropped at that edge, and a later ack is ignored.
- Pass-through has 0 added latency.
- Memory op with ack in the first BUSY cycle:
  - Cycle 0 IDLE, cycle 1 BUSY with ack, cycle 2 DONE.
  - MEM/WB captures at the end of cycle 2.
  - stall is high in cycles 0–1.
- Each extra wait cycle adds 1.
- Timeout: exactly TIMEOUT_CYCLES BUSY cycles, then DONE.
- Back-to-back memory ops: the next op is seen in the IDLE cycle following DONE, so there is no gap beyond the three-cycle minimum.

## Test plan
- ALU op: alu_result = 0x1234_5678, reg_write_en = 1, addr = 5 -> same cycle, data_out = 0x1234_5678, reg_write_en_out = 1, stall = 0, dmem_req never high.
- Signed byte load from 0x0000_0103, memory word 0x80AA_BBCC, ack after 2 BUSY cycles:
  - dmem_addr = 0x100, be = 4'b1000.
  - In DONE, data_out = 0xFFFF_FF80 and reg_write_en_out = 1.
  - stall is high for 3 cycles.
  - Repeating with mem_unsigned_in = 1 gives data_out = 0x0000_0080.
- Half store of 0xDEAD_BEEF to 0x0000_0042 -> dmem_we = 1, be = 4'b1100, wdata = 0xBEEF_BEEF, reg_write_en_out = 0 in DONE.
- Word load from 0x0000_0006 -> misalign_out = 1 for one cycle, no dmem_req, stall = 0, reg_write_en_out = 0.
- TIMEOUT_CYCLES = 4 and no ack -> dmem_req high for exactly 4 cycles, then DONE with bus_err_out = 1 and reg_write_en_out = 0. A late ack in IDLE has no effect.
- Load in BUSY with rst = 0 for one edge -> dmem_req = 0 and state IDLE on the next cycle. With the inputs unchanged and rst = 1, a new transaction starts cleanly.
